// File: rtl/cache_ctrl_fsm.sv
// Miss handler in front of a 2-way set-associative data cache.
// Serves hits in-cycle; on a miss writes back a dirty victim, refills, replays.
module cache_ctrl_fsm #(
  parameter int TAG_BITS   = 23,
  parameter int INDEX_BITS = 5,
  parameter int LINE_WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [31:0]         cpu_addr,
  input  logic [2:0]          cpu_u_b_h_w,
  input  logic [31:0]         cpu_din,
  output logic [31:0]         cpu_dout,
  output logic                cpu_stall,
  output logic [31:0]         cache_addr,
  output logic                cache_load,
  output logic                cache_store,
  output logic                cache_replace,
  output logic                cache_invalid,
  output logic [2:0]          cache_u_b_h_w,
  output logic [31:0]         cache_din,
  input  logic                cache_hit,
  input  logic                cache_valid,
  input  logic                cache_dirty,
  input  logic [TAG_BITS-1:0] cache_tag,
  input  logic [31:0]         cache_dout,
  output logic                mem_cs,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_din,
  input  logic [31:0]         mem_dout,
  input  logic                mem_ack
);

  localparam int CW  = $clog2(LINE_WORDS);
  localparam int OFF = CW + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_BACK,
    S_BACK,
    S_FILL,
    S_WAIT
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     line_q;
  logic [31:0]     victim_q;
  logic [31:0]     line_d;
  logic [31:0]     victim_d;
  logic [31:0]     woff;
  logic            last;

  assign line_d   = {cpu_addr[31:OFF], {OFF{1'b0}}};
  assign victim_d = {cache_tag,
                     cpu_addr[OFF+INDEX_BITS-1:OFF],
                     {OFF{1'b0}}};
  assign woff     = {{(30-CW){1'b0}}, cnt_q, 2'b00};
  assign last     = (cnt_q == CW'(LINE_WORDS - 1));
  assign cpu_dout = cache_dout;

  // State, word counter and latched line addresses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      victim_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cpu_req && !cache_hit) begin
            line_q   <= line_d;
            victim_q <= victim_d;
            cnt_q    <= '0;
            if (cache_valid && cache_dirty)
              state_q <= S_PRE_BACK;
            else
              state_q <= S_FILL;
          end
        end
        S_PRE_BACK: state_q <= S_BACK;
        S_BACK: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + CW'(1);
            if (last) state_q <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + CW'(1);
            if (last) state_q <= S_WAIT;
          end
        end
        S_WAIT:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Cache and memory command decode from the current state
  always_comb begin
    cpu_stall     = 1'b0;
    cache_addr    = '0;
    cache_load    = 1'b0;
    cache_store   = 1'b0;
    cache_replace = 1'b0;
    cache_invalid = 1'b0;
    cache_u_b_h_w = 3'b000;
    cache_din     = '0;
    mem_cs        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_din       = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          cache_addr    = cpu_addr;
          cache_din     = cpu_din;
          cache_u_b_h_w = cpu_u_b_h_w;
          cache_load    = ~cpu_we & cache_hit;
          cache_store   = cpu_we & cache_hit;
          cpu_stall     = ~cache_hit;
        end
      end
      S_PRE_BACK: begin
        cpu_stall     = 1'b1;
        cache_addr    = victim_q;
        cache_load    = 1'b1;
        cache_u_b_h_w = 3'b010;
      end
      S_BACK: begin
        cpu_stall     = 1'b1;
        cache_addr    = victim_q + woff;
        cache_load    = 1'b1;
        cache_u_b_h_w = 3'b010;
        mem_cs        = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = victim_q + woff;
        mem_din       = cache_dout;
      end
      S_FILL: begin
        cpu_stall = 1'b1;
        mem_cs    = 1'b1;
        mem_addr  = line_q + woff;
        if (mem_ack) begin
          cache_replace = 1'b1;
          cache_addr    = line_q + woff;
          cache_din     = mem_dout;
          cache_u_b_h_w = 3'b010;
        end
      end
      S_WAIT:  cpu_stall = 1'b1;
      default: cpu_stall = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm with a 2-way LRU cache model and a delayed-ack memory.
// Request table plus scoreboards for CPU responses and memory transactions.
module tb_cache_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic [2:0]  cpu_u_b_h_w;
  logic        cpu_stall;
  logic [31:0] cache_addr, cache_din, cache_dout;
  logic        cache_load, cache_store, cache_replace, cache_invalid;
  logic [2:0]  cache_u_b_h_w;
  logic        cache_hit, cache_valid, cache_dirty;
  logic [22:0] cache_tag;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  cache_ctrl_fsm dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_u_b_h_w(cpu_u_b_h_w), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .cache_addr(cache_addr), .cache_load(cache_load),
    .cache_store(cache_store), .cache_replace(cache_replace),
    .cache_invalid(cache_invalid), .cache_u_b_h_w(cache_u_b_h_w),
    .cache_din(cache_din), .cache_hit(cache_hit),
    .cache_valid(cache_valid), .cache_dirty(cache_dirty),
    .cache_tag(cache_tag), .cache_dout(cache_dout),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic        wb;
    logic [31:0] wbb;
    int          stalls;
    int          dly;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } memop_t;

  typedef struct {
    logic        is_load;
    logic [31:0] dout;
    int          stalls;
  } resp_t;

  memop_t      exp_ops[$];
  resp_t       exp_q[$];
  logic [31:0] mem  [1024];
  logic [31:0] gold [1024];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // Cache model: 32 sets x 2 ways x 4 words, LRU tracks CPU accesses
  logic        cv   [32][2]    = '{default: '0};
  logic        cd   [32][2]    = '{default: '0};
  logic [22:0] ctg  [32][2]    = '{default: '0};
  logic [31:0] cdat [32][2][4] = '{default: '0};
  logic        clru [32]       = '{default: '0};
  logic [4:0]  ci;
  logic [22:0] ct;
  logic [1:0]  cw;
  logic        h0, h1, hway, vw;

  always_comb begin
    ci          = cache_addr[8:4];
    ct          = cache_addr[31:9];
    cw          = cache_addr[3:2];
    h0          = cv[ci][0] && (ctg[ci][0] == ct);
    h1          = cv[ci][1] && (ctg[ci][1] == ct);
    cache_hit   = h0 | h1;
    hway        = h1;
    vw          = clru[ci];
    cache_dout  = cache_hit ? cdat[ci][hway][cw] : cdat[ci][vw][cw];
    cache_valid = cv[ci][vw];
    cache_dirty = cd[ci][vw];
    cache_tag   = ctg[ci][vw];
  end

  always @(posedge clk) begin
    if (cpu_req && !cpu_stall && (cache_load || cache_store)) begin
      clru[ci] <= ~hway;
      if (cache_store) begin
        cdat[ci][hway][cw] <= cache_din;
        cd[ci][hway]       <= 1'b1;
      end
    end
    if (cache_replace) begin
      cdat[ci][vw][cw] <= cache_din;
      cv[ci][vw]       <= 1'b1;
      cd[ci][vw]       <= 1'b0;
      ctg[ci][vw]      <= ct;
    end
  end

  // Memory: ack pulse ack_dly+1 cycles after a word request is seen
  int ack_dly = 0;
  int wcnt    = 0;

  always @(posedge clk) begin
    if (!mem_cs || mem_ack) begin
      mem_ack <= 1'b0;
      wcnt    <= 0;
    end else if (wcnt >= ack_dly) begin
      mem_ack <= 1'b1;
      wcnt    <= 0;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  assign mem_dout = mem[mem_addr[11:2]];

  logic        p_cs = 1'b0;
  logic        p_ack = 1'b0;
  logic [31:0] p_addr = '0;
  memop_t      op;

  always @(negedge clk) begin
    if (mem_cs && p_cs && !p_ack)
      chk("addr_hold", mem_addr, p_addr);
    if (mem_cs && mem_ack) begin
      total++;
      if (exp_ops.size() == 0) begin
        bad++;
        $display("FAIL unexpected_memop we=%b addr=%h", mem_we, mem_addr);
      end else begin
        op = exp_ops.pop_front();
        if (mem_we !== op.we || mem_addr !== op.addr) begin
          bad++;
          $display("FAIL memop act=%b/%h req=%b/%h",
                   mem_we, mem_addr, op.we, op.addr);
        end
        if (op.we) begin
          chk("wb_data", mem_din, op.data);
          mem[mem_addr[11:2]] = mem_din;
        end
      end
    end
    p_cs   = mem_cs;
    p_ack  = mem_ack;
    p_addr = mem_addr;
  end

  task automatic run(input vec_t v);
    int    n;
    logic  done;
    logic [31:0] d;
    resp_t e;
    ack_dly = v.dly;
    if (v.stalls > 0) begin
      if (v.wb)
        for (int i = 0; i < 4; i++)
          exp_ops.push_back('{1'b1, v.wbb + 32'(4*i),
                              gold[v.wbb[11:2] + 10'(i)]});
      for (int i = 0; i < 4; i++)
        exp_ops.push_back('{1'b0, {v.addr[31:4], 4'h0} + 32'(4*i), 32'h0});
    end
    exp_q.push_back('{~v.we, gold[v.addr[11:2]], v.stalls});
    @(posedge clk); #1;
    cpu_req     = 1'b1;
    cpu_we      = v.we;
    cpu_addr    = v.addr;
    cpu_din     = v.din;
    cpu_u_b_h_w = 3'b010;
    n    = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk);
      if (!cpu_stall) done = 1'b1;
      else n++;
    end
    d = cpu_dout;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (!done) begin
      bad++;
      $display("FAIL timeout addr=%h stalls=%0d", v.addr, n);
    end
    chk("stall_cycles", 32'(n), 32'(e.stalls));
    if (e.is_load) chk("load_data", d, e.dout);
    if (v.we) gold[v.addr[11:2]] = v.din;
    chk("memops_left", 32'(exp_ops.size()), 32'h0);
    exp_ops.delete();
  endtask

  vec_t tv[13];

  initial begin
    int   n;
    logic found;
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int   n;
    logic found;
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = 32'hA500_0000 | 32'(i << 2);
      gold[i] = 32'hA500_0000 | 32'(i << 2);
    end
    tv[0]  = '{1'b0, 32'h020, 32'h0,        1'b0, 32'h0,   10, 0};
    tv[1]  = '{1'b0, 32'h024, 32'h0,        1'b0, 32'h0,    0, 0};
    tv[2]  = '{1'b1, 32'h024, 32'h22222222, 1'b0, 32'h0,    0, 0};
    tv[3]  = '{1'b0, 32'h024, 32'h0,        1'b0, 32'h0,    0, 0};
    tv[4]  = '{1'b0, 32'h000, 32'h0,        1'b0, 32'h0,   14, 1};
    tv[5]  = '{1'b0, 32'h200, 32'h0,        1'b0, 32'h0,   10, 0};
    tv[6]  = '{1'b1, 32'h204, 32'h5555AAAA, 1'b0, 32'h0,    0, 0};
    tv[7]  = '{1'b0, 32'h000, 32'h0,        1'b0, 32'h0,    0, 0};
    tv[8]  = '{1'b0, 32'h404, 32'h0,        1'b1, 32'h200, 19, 0};
    tv[9]  = '{1'b0, 32'h204, 32'h0,        1'b0, 32'h0,   22, 3};
    tv[10] = '{1'b1, 32'h030, 32'h12345678, 1'b0, 32'h0,   22, 3};
    tv[11] = '{1'b0, 32'h030, 32'h0,        1'b0, 32'h0,    0, 0};
    tv[12] = '{1'b0, 32'h408, 32'h0,        1'b0, 32'h0,    0, 0};

    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_din = '0; cpu_u_b_h_w = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rst_mem", {30'b0, mem_cs, mem_we}, 32'h0);
    chk("rst_cmds", {28'b0, cache_load, cache_store,
                     cache_replace, cache_invalid}, 32'h0);
    chk("rst_addr", cache_addr, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 13; i++) run(tv[i]);

    run('{1'b1, 32'h050, 32'hDEADBEEF, 1'b0, 32'h0, 10, 0});
    run('{1'b0, 32'h250, 32'h0,        1'b0, 32'h0, 10, 0});
    ack_dly = 0;
    exp_ops.push_back('{1'b1, 32'h050, gold[20]});
    exp_ops.push_back('{1'b1, 32'h054, gold[21]});
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h450;
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clk);
      if (mem_cs && mem_we && mem_addr == 32'h058) found = 1'b1;
      else n++;
    end
    chk("abort_reached", {31'b0, found}, 32'h1);
    #1 rst = 1'b0; cpu_req = 1'b0;
    #1;
    chk("abort_mem", {30'b0, mem_cs, mem_we}, 32'h0);
    chk("abort_stall", {31'b0, cpu_stall}, 32'h0);
    chk("abort_cmds", {28'b0, cache_load, cache_store,
                       cache_replace, cache_invalid}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("abort_ops_left", 32'(exp_ops.size()), 32'h0);
    exp_ops.delete();
    run('{1'b0, 32'h450, 32'h0, 1'b1, 32'h050, 19, 0});
    run('{1'b0, 32'h454, 32'h0, 1'b0, 32'h0,    0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
Cache management FSM that sits directly upstream of the 2-way set-associative data cache. It sits between the CPU memory-stage request and both the cache array and main memory. Hits are served in the same cycle with no stall. Misses stall the CPU, write back a dirty victim line word-by-word, refill the line from memory through the cache `replace` port, then replay the original access.

Parameters:
TAG_BITS, 23, tag width; must equal 32 - INDEX_BITS - 2 - log2(LINE_WORDS)
INDEX_BITS, 5, set index width (32 sets)
LINE_WORDS, 4, words per line (power of two, >= 2)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  access request valid; CPU holds all request fields stable while cpu_stall=1
cpu_we  in  1  1=store, 0=load
cpu_addr  in  32  byte address
cpu_u_b_h_w  in  3  access size/sign, passed to cache unchanged
cpu_din  in  32  store data
cpu_dout  out  32  load data (= cache_dout)
cpu_stall  out  1  request not yet complete
cache_addr  out  32  address to cache
cache_load / cache_store / cache_replace / cache_invalid  out  1 each  cache commands (cache_invalid is always 0)
cache_u_b_h_w  out  3  access size to cache
cache_din  out  32  data to cache
cache_hit / cache_valid / cache_dirty  in  1 each  cache status for cache_addr
cache_tag  in  TAG_BITS  tag of the victim line chosen by LRU
cache_dout  in  32  cache read data
mem_cs  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  32  word-aligned memory address
mem_din  out  32  write data to memory
mem_dout  in  32  read data from memory
mem_ack  in  1  one-cycle pulse: current word done (read data valid in that cycle)

Behaviour:
- Address split: tag = addr[31 -: TAG_BITS]; index = next INDEX_BITS; word = next log2(LINE_WORDS) bits; byte = [1:0].
- States: IDLE, PRE_BACK, BACK, FILL, WAIT. Word counter cnt has log2(LINE_WORDS) bits.
- Reset (async): state=IDLE, cnt=0, latched registers=0.
- Outputs in IDLE with cpu_req=0 are all 0.
- Reset mid-miss aborts the transfer. mem_cs drops immediately; there is no partial-line recovery.
- IDLE with cpu_req=1:
  - Combinationally drive cache_addr=cpu_addr, cache_load=~cpu_we, cache_store=cpu_we, cache_din=cpu_din, cache_u_b_h_w=cpu_u_b_h_w.
  - cache_hit=1: cpu_stall=0 and the access completes this cycle (store sets dirty inside the cache). State stays IDLE.
  - cache_hit=0: cache_load and cache_store are forced to 0 and cpu_stall=1.
  - On the miss, latch line base = {addr[31:offset], 0} and victim base = {cache_tag, index, 0}.
  - Next state is PRE_BACK if cache_valid&cache_dirty, else FILL. cnt is set to 0.
- PRE_BACK (1 cycle): cache_addr=victim base, cache_load=1, u_b_h_w=3'b010. Next state BACK.
- BACK:
  - cache_addr = victim base + 4*cnt, cache_load=1.
  - mem_cs=1, mem_we=1, mem_addr = cache_addr, mem_din=cache_dout.
  - On mem_ack: cnt++. On the ack with cnt=LINE_WORDS-1, cnt wraps to 0 and state goes to FILL.
- FILL:
  - mem_cs=1, mem_we=0, mem_addr = line base + 4*cnt.
  - On mem_ack, in the same cycle: cache_replace=1, cache_addr=mem_addr, cache_din=mem_dout, u_b_h_w=3'b010; cnt++.
  - On the last word's ack, cnt wraps to 0 and state goes to WAIT.
  - The cache sets valid=1, dirty=0 and the new tag on replace.
- WAIT (1 cycle, cpu_stall=1, no commands) -> IDLE. IDLE then replays the still-held request, which now hits; a store sets dirty.
- cpu_stall=1 in every non-IDLE state.
- mem_cs stays high across words within BACK/FILL, including BACK->FILL, and stays high while waiting for mem_ack (no timeout).
- mem_ack outside BACK/FILL is ignored.
- A miss with the victim valid but clean, or invalid, skips writeback entirely.

Test Plan:
1. Cold load 0x00000020 (miss, victim invalid) -> no mem_we. FILL reads 0x20,0x24,0x28,0x2C. Replay returns mem word at 0x20. Stall = 4 acks + 2 cycles.
2. After 1, load 0x00000024 -> cpu_stall=0 same cycle, cpu_dout=word at 0x24, mem_cs never asserted.
3. Store 0x22222222 to 0x00000024 (hit) -> no stall. Then load 0x24 returns 0x22222222.
4. Line 0x000 and line 0x200 both resident in set 0, line 0x200 dirty and LRU. Load 0x00000404 -> BACK writes 0x200..0x20C with the cached data. FILL reads 0x400..0x40C. Replay hits.
5. mem_ack delayed 3 cycles per word -> mem_cs held, mem_addr stable until each ack. Word order is unchanged.
6. Assert rst=0 during BACK word 2 -> mem_cs, cpu_stall and all cache commands go to 0 immediately. After release the FSM is in IDLE with cnt=0.
